cpu_phase_sequencer: RTL

Instruction-cycle controller for the 16-bit CPU. Generates the one-hot FETCH / EXEC1 / EXEC2 phase strobes consumed by the instruction decoder. Extends an instruction into EXEC2 when the decoder requests it, stalls on RAM wait, and supports run / single-step / stop. Also maintains retired-instruction and active-cycle counters and a memory-stall watchdog.

---
 rtl/cpu_phase_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/cpu_phase_sequencer.sv
// Instruction-cycle controller: one-hot FETCH/EXEC1/EXEC2 strobes with run/step/stop,
// RAM-wait stalls, a stall watchdog and retired-instruction / active-cycle counters.
module cpu_phase_sequencer #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             RUN,
  input  logic             STEP,
  input  logic             E2,
  input  logic             STP,
  input  logic             MEM_WAIT,
  output logic             FETCH,
  output logic             EXEC1,
  output logic             EXEC2,
  output logic             HALTED,
  output logic             FAULT,
  output logic             IDLE,
  output logic [CNT_W-1:0] INSTR_COUNT,
  output logic [CNT_W-1:0] CYCLE_COUNT
);

  localparam int WAIT_W = $clog2(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_EXEC1   = 3'd2,
    S_EXEC2   = 3'd3,
    S_STOPPED = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  state_t             state_r;
  state_t             next_state_s;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic               step_req_r;
  logic               step_prev_r;
  logic [CNT_W-1:0]   instr_cnt_r;
  logic [CNT_W-1:0]   cycle_cnt_r;
  logic               fetch_r, exec1_r, exec2_r, halted_r, fault_r, idle_r;
  logic               fetch_s, exec1_s, exec2_s, halted_s, fault_s, idle_s;
  logic               step_edge_s;
  logic               go_on_s;
  logic               retire_s;
  logic               wait_inc_s;
  logic               wait_full_s;
  logic               active_s;
  logic               enter_fetch_s;

  // Next-state decision: stalls, watchdog, retirement and run/step continuation.
  always_comb begin
    step_edge_s  = STEP & ~step_prev_r & ~RUN;
    // The current-cycle step edge counts so a step can start or chain without a bubble.
    go_on_s      = RUN | step_req_r | step_edge_s;
    wait_full_s  = (wait_cnt_r == WAIT_LAST);
    next_state_s = state_r;
    retire_s     = 1'b0;
    wait_inc_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (go_on_s) next_state_s = S_FETCH;
        else         next_state_s = S_IDLE;
      end
      S_FETCH: begin
        if (MEM_WAIT) begin
          if (wait_full_s) next_state_s = S_FAULT;
          else begin
            next_state_s = S_FETCH;
            wait_inc_s   = 1'b1;
          end
        end else begin
          next_state_s = S_EXEC1;
        end
      end
      S_EXEC1: begin
        if (STP) begin
          next_state_s = S_STOPPED;
          retire_s     = 1'b1;
        end else if (MEM_WAIT) begin
          if (wait_full_s) next_state_s = S_FAULT;
          else begin
            next_state_s = S_EXEC1;
            wait_inc_s   = 1'b1;
          end
        end else if (E2) begin
          next_state_s = S_EXEC2;
        end else begin
          retire_s     = 1'b1;
          next_state_s = go_on_s ? S_FETCH : S_IDLE;
        end
      end
      S_EXEC2: begin
        if (MEM_WAIT) begin
          if (wait_full_s) next_state_s = S_FAULT;
          else begin
            next_state_s = S_EXEC2;
            wait_inc_s   = 1'b1;
          end
        end else begin
          retire_s     = 1'b1;
          next_state_s = go_on_s ? S_FETCH : S_IDLE;
        end
      end
      S_STOPPED: next_state_s = S_STOPPED;
      S_FAULT:   next_state_s = S_FAULT;
      default:   next_state_s = S_FAULT;
    endcase
  end

  // Strobe decode of the upcoming state so registered outputs track the state register.
  always_comb begin
    fetch_s  = 1'b0;
    exec1_s  = 1'b0;
    exec2_s  = 1'b0;
    halted_s = 1'b0;
    fault_s  = 1'b0;
    idle_s   = 1'b0;
    case (next_state_s)
      S_IDLE:    idle_s   = 1'b1;
      S_FETCH:   fetch_s  = 1'b1;
      S_EXEC1:   exec1_s  = 1'b1;
      S_EXEC2:   exec2_s  = 1'b1;
      S_STOPPED: halted_s = 1'b1;
      S_FAULT:   fault_s  = 1'b1;
      default:   fault_s  = 1'b1;
    endcase
    active_s      = (state_r == S_FETCH) | (state_r == S_EXEC1) | (state_r == S_EXEC2);
    enter_fetch_s = (next_state_s == S_FETCH) & (state_r != S_FETCH);
  end

  // State, step latch, watchdog, counters and output registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r     <= S_IDLE;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      step_req_r  <= 1'b0;
      step_prev_r <= 1'b0;
      instr_cnt_r <= {CNT_W{1'b0}};
      cycle_cnt_r <= {CNT_W{1'b0}};
      fetch_r     <= 1'b0;
      exec1_r     <= 1'b0;
      exec2_r     <= 1'b0;
      halted_r    <= 1'b0;
      fault_r     <= 1'b0;
      idle_r      <= 1'b1;
    end else begin
      state_r     <= next_state_s;
      step_prev_r <= STEP;
      if (enter_fetch_s)    step_req_r <= 1'b0;
      else if (step_edge_s) step_req_r <= 1'b1;
      else                  step_req_r <= step_req_r;
      if (wait_inc_s) wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      else            wait_cnt_r <= {WAIT_W{1'b0}};
      if (retire_s) instr_cnt_r <= instr_cnt_r + CNT_W'(1);
      else          instr_cnt_r <= instr_cnt_r;
      if (active_s) cycle_cnt_r <= cycle_cnt_r + CNT_W'(1);
      else          cycle_cnt_r <= cycle_cnt_r;
      fetch_r     <= fetch_s;
      exec1_r     <= exec1_s;
      exec2_r     <= exec2_s;
      halted_r    <= halted_s;
      fault_r     <= fault_s;
      idle_r      <= idle_s;
    end
  end

  assign FETCH       = fetch_r;
  assign EXEC1       = exec1_r;
  assign EXEC2       = exec2_r;
  assign HALTED      = halted_r;
  assign FAULT       = fault_r;
  assign IDLE        = idle_r;
  assign INSTR_COUNT = instr_cnt_r;
  assign CYCLE_COUNT = cycle_cnt_r;

endmodule
